// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scan driver for NUM_DIGITS digits.
// Double-buffered data with frame-synchronous update, leading-zero blanking and an anti-ghost gap.
module seg7_scan_driver #(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned CLK_DIV    = 1000,
   parameter int unsigned BLANK_CYC  = 1,
   parameter bit          HEX_MODE   = 1'b1,
   parameter bit          ACTIVE_LOW = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   dp,
   input  logic                    blank_lz,
   output logic [6:0]              seg,
   output logic                    seg_dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame
);

   localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
   localparam logic [6:0]            SEG_OFF = {7{ACTIVE_LOW}};
   localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{ACTIVE_LOW}};

   logic [CW-1:0]           cnt_q;
   logic [IW-1:0]           idx_q;
   logic [4*NUM_DIGITS-1:0] hold_digits_q, disp_digits_q;
   logic [NUM_DIGITS-1:0]   hold_dp_q, disp_dp_q;

   logic                  wrap;
   logic [3:0]            cur_val;
   logic                  cur_dp;
   logic [6:0]            glyph;
   logic [NUM_DIGITS-1:0] lz;
   logic                  blank;
   logic [6:0]            seg_raw;
   logic                  dp_raw;
   logic [NUM_DIGITS-1:0] an_raw;

   function automatic logic [6:0] decode(input logic [3:0] v);
      logic [6:0] g;
      unique case (v)
         4'h0: g = 7'h7E;  4'h1: g = 7'h30;  4'h2: g = 7'h6D;  4'h3: g = 7'h79;
         4'h4: g = 7'h33;  4'h5: g = 7'h5B;  4'h6: g = 7'h5F;  4'h7: g = 7'h70;
         4'h8: g = 7'h7F;  4'h9: g = 7'h7B;  4'hA: g = 7'h77;  4'hB: g = 7'h1F;
         4'hC: g = 7'h4E;  4'hD: g = 7'h3D;  4'hE: g = 7'h4F;  default: g = 7'h47;
      endcase
      if (!HEX_MODE && v > 4'd9) g = 7'h00;
      return g;
   endfunction

   // lz[i]: digit i and all more-significant digits are zero with no dp set
   always_comb begin
      logic run;
      run = 1'b1;
      lz  = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         run   = run & (disp_digits_q[4*i +: 4] == 4'd0) & ~disp_dp_q[i];
         lz[i] = run;
      end
      lz[0] = 1'b0;
   end

   always_comb begin
      wrap    = en && (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
      cur_val = disp_digits_q[4*idx_q +: 4];
      cur_dp  = disp_dp_q[idx_q];
      glyph   = decode(cur_val);
      blank   = blank_lz && lz[idx_q];
      seg_raw = (en && !blank) ? glyph : 7'h00;
      dp_raw  = en && !blank && cur_dp;
      an_raw  = (en && cnt_q >= CNT_BLANK) ? (NUM_DIGITS'(1) << idx_q) : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q         <= '0;
         idx_q         <= '0;
         hold_digits_q <= '0;
         hold_dp_q     <= '0;
         disp_digits_q <= '0;
         disp_dp_q     <= '0;
         frame         <= 1'b0;
         seg           <= SEG_OFF;
         seg_dp        <= ACTIVE_LOW;
         an            <= AN_OFF;
      end else begin
         if (load) begin
            hold_digits_q <= digits;
            hold_dp_q     <= dp;
         end
         // Display takes the pre-edge holding value, so a load on the wrap edge waits a frame
         if (!en || wrap) begin
            disp_digits_q <= hold_digits_q;
            disp_dp_q     <= hold_dp_q;
         end
         if (en) begin
            if (cnt_q == CNT_LAST) begin
               cnt_q <= '0;
               idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
         frame  <= wrap;
         seg    <= seg_raw ^ SEG_OFF;
         seg_dp <= dp_raw ^ ACTIVE_LOW;
         an     <= an_raw ^ AN_OFF;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: hex, decimal-only and active-low instances in lockstep.
module tb_seg7_scan_driver;

   logic        clk = 1'b0;
   logic        rst, en, load, blank_lz;
   logic [15:0] digits;
   logic [3:0]  dp;

   logic [6:0] seg_m, seg_h, seg_l;
   logic       sdp_m, sdp_h, sdp_l;
   logic [3:0] an_m, an_h, an_l;
   logic       fr_m, fr_h, fr_l;

   int n_cmp = 0;
   int n_bad = 0;

   logic [12:0] exp_q[$];
   string       tag_q[$];

   always #5 clk = ~clk;

   seg7_scan_driver #(.NUM_DIGITS(4), .CLK_DIV(4), .BLANK_CYC(1), .HEX_MODE(1'b1),
                      .ACTIVE_LOW(1'b0)) u_main (
      .clk(clk), .rst(rst), .en(en), .load(load), .digits(digits), .dp(dp),
      .blank_lz(blank_lz), .seg(seg_m), .seg_dp(sdp_m), .an(an_m), .frame(fr_m));

   seg7_scan_driver #(.NUM_DIGITS(4), .CLK_DIV(4), .BLANK_CYC(1), .HEX_MODE(1'b0),
                      .ACTIVE_LOW(1'b0)) u_dec (
      .clk(clk), .rst(rst), .en(en), .load(load), .digits(digits), .dp(dp),
      .blank_lz(blank_lz), .seg(seg_h), .seg_dp(sdp_h), .an(an_h), .frame(fr_h));

   seg7_scan_driver #(.NUM_DIGITS(4), .CLK_DIV(4), .BLANK_CYC(1), .HEX_MODE(1'b1),
                      .ACTIVE_LOW(1'b1)) u_alow (
      .clk(clk), .rst(rst), .en(en), .load(load), .digits(digits), .dp(dp),
      .blank_lz(blank_lz), .seg(seg_l), .seg_dp(sdp_l), .an(an_l), .frame(fr_l));

   function automatic logic [12:0] observe(input int inst);
      case (inst)
         0:       return {seg_m, sdp_m, an_m, fr_m};
         1:       return {seg_h, sdp_h, an_h, fr_h};
         default: return {seg_l, sdp_l, an_l, fr_l};
      endcase
   endfunction

   // Expectations are written active-high; the active-low instance gets them inverted
   task automatic expect_next(input int inst, input logic [6:0] s, input logic d,
                              input logic [3:0] a, input logic f, input string tag);
      logic [12:0] e, o;
      string       t;
      if (inst == 2) begin
         s = ~s;
         d = ~d;
         a = ~a;
      end
      exp_q.push_back({s, d, a, f});
      tag_q.push_back(tag);
      @(negedge clk);
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      o = observe(inst);
      n_cmp++;
      assert (o === e) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", t, o, e);
      end
   endtask

   task automatic wait_frame(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 64 && !seen; i++) begin
         @(negedge clk);
         load = 1'b0;
         if (fr_m === 1'b1) seen = 1'b1;
      end
      n_cmp++;
      assert (seen) else begin
         n_bad++;
         $error("FAIL %s: frame observed 0 expected 1 within 64 cycles", tag);
      end
   endtask

   // One full 16-cycle frame following a frame pulse; optional load driven after sample ld_at
   task automatic check_frame(input int inst, input logic [27:0] g, input logic [3:0] dpv,
                              input int ld_at, input logic [15:0] ld_val, input string tag);
      int         d, c;
      logic [3:0] a;
      for (int k = 1; k <= 16; k++) begin
         d = (k - 1) / 4;
         c = (k - 1) % 4;
         a = (c >= 1) ? (4'b0001 << d) : 4'b0000;
         expect_next(inst, g[7*d +: 7], dpv[d], a, k == 16,
                     $sformatf("%s d%0d c%0d", tag, d, c));
         if (k == ld_at) begin
            load   = 1'b1;
            digits = ld_val;
         end else begin
            load = 1'b0;
         end
      end
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] p);
      digits = v;
      dp     = p;
      load   = 1'b1;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; load = 1'b0; blank_lz = 1'b0; digits = '0; dp = '0;
      expect_next(0, 7'h00, 1'b0, 4'h0, 1'b0, "reset main");
      expect_next(1, 7'h00, 1'b0, 4'h0, 1'b0, "reset dec");
      expect_next(2, 7'h00, 1'b0, 4'h0, 1'b0, "reset alow");

      rst = 1'b0;
      en  = 1'b1;
      do_load(16'h1234, 4'h0);
      wait_frame("basic");
      check_frame(0, {7'h30, 7'h6D, 7'h79, 7'h33}, 4'h0, 0, 16'h0, "basic");

      do_load(16'hABCF, 4'h0);
      wait_frame("hex");
      check_frame(0, {7'h77, 7'h1F, 7'h4E, 7'h47}, 4'h0, 0, 16'h0, "hex");
      check_frame(1, 28'h0, 4'h0, 0, 16'h0, "dec");

      blank_lz = 1'b1;
      do_load(16'h0050, 4'h0);
      wait_frame("lz");
      check_frame(0, {7'h00, 7'h00, 7'h5B, 7'h7E}, 4'h0, 0, 16'h0, "lz");
      do_load(16'h0050, 4'b0100);
      wait_frame("lz dp");
      check_frame(0, {7'h00, 7'h7E, 7'h5B, 7'h7E}, 4'b0100, 0, 16'h0, "lz dp");
      do_load(16'h0000, 4'h0);
      wait_frame("lz zero");
      check_frame(0, {7'h00, 7'h00, 7'h00, 7'h7E}, 4'h0, 0, 16'h0, "lz zero");

      blank_lz = 1'b0;
      do_load(16'h1111, 4'h0);
      wait_frame("tear");
      check_frame(0, {4{7'h30}}, 4'h0, 8, 16'h2222, "tear old");
      check_frame(0, {4{7'h6D}}, 4'h0, 15, 16'h3333, "tear new");
      check_frame(0, {4{7'h6D}}, 4'h0, 0, 16'h0, "wrap miss");
      check_frame(0, {4{7'h79}}, 4'h0, 0, 16'h0, "wrap late");

      // Freeze at digit 1, cnt 1; data loaded while frozen goes straight to the display
      repeat (5) @(negedge clk);
      en = 1'b0;
      do_load(16'h4321, 4'h0);
      expect_next(0, 7'h00, 1'b0, 4'h0, 1'b0, "en off 0");
      load = 1'b0;
      expect_next(0, 7'h00, 1'b0, 4'h0, 1'b0, "en off 1");
      expect_next(0, 7'h00, 1'b0, 4'h0, 1'b0, "en off 2");
      en = 1'b1;
      expect_next(0, 7'h6D, 1'b0, 4'b0010, 1'b0, "resume d1 c1");
      expect_next(0, 7'h6D, 1'b0, 4'b0010, 1'b0, "resume d1 c2");
      expect_next(0, 7'h6D, 1'b0, 4'b0010, 1'b0, "resume d1 c3");
      expect_next(0, 7'h79, 1'b0, 4'b0000, 1'b0, "resume d2 c0");
      expect_next(0, 7'h79, 1'b0, 4'b0100, 1'b0, "resume d2 c1");

      rst = 1'b1;
      expect_next(0, 7'h00, 1'b0, 4'h0, 1'b0, "mid reset");
      rst = 1'b0;
      expect_next(0, 7'h7E, 1'b0, 4'b0000, 1'b0, "post reset d0 c0");
      expect_next(0, 7'h7E, 1'b0, 4'b0001, 1'b0, "post reset d0 c1");
      expect_next(0, 7'h7E, 1'b0, 4'b0001, 1'b0, "post reset d0 c2");
      expect_next(0, 7'h7E, 1'b0, 4'b0001, 1'b0, "post reset d0 c3");
      expect_next(0, 7'h7E, 1'b0, 4'b0000, 1'b0, "post reset d1 c0");

      do_load(16'h0010, 4'h0);
      wait_frame("alow");
      check_frame(2, {7'h7E, 7'h7E, 7'h30, 7'h7E}, 4'h0, 0, 16'h0, "alow");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for a bank of common-anode/cathode 7-segment digits, generalising the single-digit hex decoder to `NUM_DIGITS` channels. Each digit has a per-digit decimal point and an optional hex or decimal-only glyph set. Leading-zero blanking, an anti-ghosting blank interval and tear-free frame-synchronous update are also provided. It sits between the counter/datapath logic and the board display pins.

## Interface
- `NUM_DIGITS`, 4: number of digits scanned (2..8).
- `CLK_DIV`, 1000: clock cycles per digit slot (≥2).
- `BLANK_CYC`, 1: cycles at start of each slot with all anodes off. Must satisfy `BLANK_CYC < CLK_DIV`.
- `HEX_MODE`, 1: 1 = values 10..15 show A,b,C,d,E,F; 0 = values 10..15 blank the digit.
- `ACTIVE_LOW`, 0: 1 inverts `seg`, `seg_dp` and `an` at the output register.
- `clk`, in, 1: sole clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `en`, in, 1: 1 = scan and drive; 0 = freeze scan, all outputs inactive.
- `load`, in, 1: capture `digits`/`dp` into the holding register this cycle.
- `digits`, in, 4*NUM_DIGITS: BCD/hex nibbles. Digit 0 = `[3:0]` = least significant.
- `dp`, in, NUM_DIGITS: decimal point per digit, bit i ↔ digit i.
- `blank_lz`, in, 1: enable leading-zero blanking.
- `seg`, out, 7: segments a..g, a = bit 6, g = bit 0.
- `seg_dp`, out, 1: decimal-point segment.
- `an`, out, NUM_DIGITS: one-hot digit enable (or all inactive).
- `frame`, out, 1: one-cycle pulse on each scan wrap.

## Operation
- Glyphs (active-high): 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B A=77 b=1F C=4E d=3D E=4F F=47. Blank = 00.
- Two register stages:
  - Holding register: written on any cycle with `load=1`.
  - Display register: copied from the holding register's pre-edge value on the edge where `idx` wraps NUM_DIGITS-1→0 (the `frame` edge).
  - While `en=0`, the display register copies the holding register every cycle.
- Scan state: `cnt` (0..CLK_DIV-1) and `idx` (0..NUM_DIGITS-1). Both advance only when `en=1`.
  - `cnt` increments each cycle.
  - At `cnt=CLK_DIV-1`: `cnt`→0 and `idx`→idx+1. At `idx=NUM_DIGITS-1`, `idx` wraps to 0.
- Leading-zero blanking, applied when `blank_lz=1`: digit i is blanked (seg=00, seg_dp=0) if it and every more-significant digit are 0 **and** none of those digits has `dp` set. Digit 0 is never blanked.
- `an` active for digit `idx` only when `en=1` and `cnt ≥ BLANK_CYC`; otherwise all inactive. `seg`/`seg_dp` reflect digit `idx` regardless of the blank interval.
- `en=0`: `seg`=00, `seg_dp`=0, `an`=0 (pre-inversion); `cnt`/`idx` hold their values; `frame`=0.

## Timing
- All outputs are registered: they reflect the `(cnt, idx)` and display-register state of the previous cycle, i.e. a 1-cycle latency.
- `frame`=1 in the cycle after the wrap edge, for exactly one cycle. Period = NUM_DIGITS·CLK_DIV cycles.
- Load to visible: new data appears on digit 0 one cycle after the next `frame` edge. A `load` coincident with the wrap edge misses that frame and shows one frame later.
- Reset: `cnt`=0, `idx`=0, holding and display registers = 0, `frame`=0. `seg`, `seg_dp` and `an` all inactive (all 1 when `ACTIVE_LOW=1`). First output update occurs on the first edge with `rst=0`.
- Reset mid-scan aborts the slot immediately; the scan restarts at digit 0 with `cnt`=0.
- `rst` has priority over `load` and `en`.

## Test plan
All scenarios use NUM_DIGITS=4, CLK_DIV=4, BLANK_CYC=1 unless stated.
- **Basic scan.** Reset, then `load` digits=0x1234, dp=0, `en=1`. After the first `frame`, each 4-cycle slot shows 1 cycle of `an`=0000, then 3 cycles with `an`=0001/seg=33, then 0010/seg=79, 0100/6D, 1000/30. `frame` pulses every 16 cycles.
- **Hex vs decimal glyphs.** digits=0xABCF. With HEX_MODE=1: seg 47, 4E, 1F, 77 for digits 0..3. With HEX_MODE=0: all four slots show seg=00.
- **Leading-zero blanking.**
  - digits=0x0050, `blank_lz=1`: digits 3 and 2 show 00; digit 1 shows 5B; digit 0 shows 7E.
  - Same data with dp=4'b0100: digit 2 shows 7E with `seg_dp`=1.
  - digits=0x0000: only digit 0 is lit, showing 7E.
- **Tear-free update.** Load 0x1111, then load 0x2222 mid-frame. The current frame keeps showing 30 on every digit. The next frame shows 6D.
- **Load on wrap edge.** A load coincident with the wrap edge appears one frame later.
- **Enable, reset and polarity.**
  - Drop `en` mid-slot: outputs go inactive next cycle and `cnt`/`idx` freeze. Raise `en`: the scan resumes at the same `cnt`/`idx`.
  - Assert `rst` for 1 cycle mid-scan: the next slot is digit 0 with `cnt`=0.
  - With ACTIVE_LOW=1 and digit 1: observe seg=7'h4F and an=4'b1101 in the active part of its slot.
